// File: rtl/systolic_result_drain_if.sv
// Result stream from the systolic readout stage: one accumulator per
// handshake, carried both raw and requantized, with its row/column position.
interface systolic_result_drain_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int ROW_W = 2,
    parameter int COL_W = 2
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_acc;
    logic [IN_W-1:0]  out_q;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;
    logic             out_last;

    modport master (
        output out_valid, out_acc, out_q, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_acc, out_q, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/systolic_result_drain.sv
// Readout stage behind the systolic MAC array: captures all accumulators on
// the rising edge of compute_done and streams them out in row-major order,
// raw and requantized (optional ReLU, arithmetic shift, saturation).
module systolic_result_drain #(
    parameter int num_row       = 3,
    parameter int num_col       = 3,
    parameter int in_word_size  = 8,
    parameter int out_word_size = 16,
    parameter int shift         = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          compute_done,
    input  logic [0:out_word_size*num_row*num_col-1]      pe_register_vals,
    input  logic                                          relu_en,
    systolic_result_drain_if.master                       out_if,
    output logic                                          busy,
    output logic                                          drain_done,
    output logic                                          missed
);
    localparam int N  = num_row * num_col;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (num_row > 1) ? $clog2(num_row) : 1;
    localparam int CW = (num_col > 1) ? $clog2(num_col) : 1;

    localparam logic [KW-1:0] LAST_K  = KW'(N - 1);
    localparam logic [CW-1:0] LAST_C  = CW'(num_col - 1);
    localparam logic signed [out_word_size-1:0] Q_MAX =
        {{(out_word_size-in_word_size+1){1'b0}}, {(in_word_size-1){1'b1}}};
    localparam logic signed [out_word_size-1:0] Q_MIN =
        {{(out_word_size-in_word_size+1){1'b1}}, {(in_word_size-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Requantize one accumulator: ReLU, arithmetic shift, saturate to in_word_size.
    function automatic logic [in_word_size-1:0] quantize(
        input logic [out_word_size-1:0] a,
        input logic                     relu
    );
        logic signed [out_word_size-1:0] s;
        logic [in_word_size-1:0]         r;
        if (relu && a[out_word_size-1]) begin
            s = '0;
        end else begin
            s = $signed(a) >>> shift;
        end
        if (s > Q_MAX) begin
            r = Q_MAX[in_word_size-1:0];
        end else if (s < Q_MIN) begin
            r = Q_MIN[in_word_size-1:0];
        end else begin
            r = s[in_word_size-1:0];
        end
        return r;
    endfunction

    state_t                   state_q, state_d;
    logic                     cd_prev_q, cd_prev_d;
    logic [KW-1:0]            idx_q, idx_d;
    logic [RW-1:0]            row_q, row_d;
    logic [CW-1:0]            col_q, col_d;
    logic                     relu_q, relu_d;
    logic                     missed_q, missed_d;
    logic                     out_valid_q, out_valid_d;
    logic [out_word_size-1:0] out_acc_q, out_acc_d;
    logic [in_word_size-1:0]  quant_q, quant_d;
    logic                     out_last_q, out_last_d;
    logic                     busy_q, busy_d;
    logic                     drain_done_q, drain_done_d;
    logic                     snap_load_s;
    logic                     rise_s;
    logic [KW-1:0]            idx_next_s;
    logic [out_word_size-1:0] elem0_s;
    logic [out_word_size-1:0] snap_next_s;
    logic [out_word_size-1:0] snap_q [N];

    assign rise_s      = compute_done & ~cd_prev_q;
    assign idx_next_s  = idx_q + KW'(1);
    assign elem0_s     = pe_register_vals[0 +: out_word_size];
    assign snap_next_s = snap_q[idx_next_s];

    // Snapshot of the whole accumulator bus, written only at capture.
    always_ff @(posedge clk) begin
        if (snap_load_s) begin
            for (int k = 0; k < N; k++) begin
                snap_q[k] <= pe_register_vals[out_word_size*k +: out_word_size];
            end
        end
    end

    // Next-state and next-output logic; outputs are prepared one cycle ahead
    // so every stream output comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        cd_prev_d    = compute_done;
        idx_d        = idx_q;
        row_d        = row_q;
        col_d        = col_q;
        relu_d       = relu_q;
        missed_d     = missed_q;
        out_valid_d  = out_valid_q;
        out_acc_d    = out_acc_q;
        quant_d      = quant_q;
        out_last_d   = out_last_q;
        busy_d       = busy_q;
        drain_done_d = 1'b0;
        snap_load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    snap_load_s = 1'b1;
                    relu_d      = relu_en;
                    idx_d       = '0;
                    row_d       = '0;
                    col_d       = '0;
                    out_acc_d   = elem0_s;
                    quant_d     = quantize(elem0_s, relu_en);
                    out_valid_d = 1'b1;
                    out_last_d  = (LAST_K == '0);
                    busy_d      = 1'b1;
                    state_d     = ST_DRAIN;
                end else begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (rise_s) begin
                    missed_d = 1'b1;
                end else begin
                    missed_d = missed_q;
                end
                if (out_if.out_ready) begin
                    if (out_last_q) begin
                        out_valid_d  = 1'b0;
                        out_last_d   = 1'b0;
                        drain_done_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        idx_d      = idx_next_s;
                        out_acc_d  = snap_next_s;
                        quant_d    = quantize(snap_next_s, relu_q);
                        out_last_d = (idx_next_s == LAST_K);
                        if (col_q == LAST_C) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (rise_s) begin
                    missed_d = 1'b1;
                end else begin
                    missed_d = missed_q;
                end
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cd_prev_q    <= 1'b0;
            idx_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            relu_q       <= 1'b0;
            missed_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_acc_q    <= '0;
            quant_q      <= '0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cd_prev_q    <= cd_prev_d;
            idx_q        <= idx_d;
            row_q        <= row_d;
            col_q        <= col_d;
            relu_q       <= relu_d;
            missed_q     <= missed_d;
            out_valid_q  <= out_valid_d;
            out_acc_q    <= out_acc_d;
            quant_q      <= quant_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_acc   = out_acc_q;
    assign out_if.out_q     = quant_q;
    assign out_if.out_row   = row_q;
    assign out_if.out_col   = col_q;
    assign out_if.out_last  = out_last_q;
    assign busy             = busy_q;
    assign drain_done       = drain_done_q;
    assign missed           = missed_q;
endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: queue-based reference model compared every
// cycle, plus directed literal checks on captured drains.
module tb_systolic_result_drain;
    localparam int NR = 3;
    localparam int NC = 3;
    localparam int IW = 8;
    localparam int OW = 16;
    localparam int SH = 4;
    localparam int N  = NR * NC;
    localparam int RW = 2;
    localparam int CW = 2;

    typedef struct packed {
        logic [OW-1:0] acc;
        logic [IW-1:0] q;
        logic [7:0]    row;
        logic [7:0]    col;
        logic          last;
    } word_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            compute_done;
    logic            relu_en;
    logic [0:OW*N-1] pe_vals;
    logic            busy;
    logic            drain_done;
    logic            missed;

    systolic_result_drain_if #(.IN_W(IW), .OUT_W(OW), .ROW_W(RW), .COL_W(CW)) bus ();

    systolic_result_drain #(
        .num_row(NR), .num_col(NC), .in_word_size(IW), .out_word_size(OW), .shift(SH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .compute_done     (compute_done),
        .pe_register_vals (pe_vals),
        .relu_en          (relu_en),
        .out_if           (bus),
        .busy             (busy),
        .drain_done       (drain_done),
        .missed           (missed)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    int    done_cnt = 0;
    word_t exp_q[$];
    word_t log_q[$];
    bit    m_done = 1'b0;
    bit    m_missed = 1'b0;
    bit    m_cd_prev = 1'b0;
    bit    m_known = 1'b0;
    bit    m_chk_zero = 1'b0;
    bit    m_edge;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level quantization with plain integer arithmetic.
    function automatic logic [IW-1:0] ref_quant(input logic [OW-1:0] a, input logic relu);
        int v;
        int s;
        v = int'($signed(a));
        s = v >>> SH;
        if (relu && v < 0) s = 0;
        if (s > 2**(IW-1) - 1) s = 2**(IW-1) - 1;
        if (s < -(2**(IW-1))) s = -(2**(IW-1));
        return s[IW-1:0];
    endfunction

    // Compare outputs against the model, then advance the model by one cycle.
    always @(negedge clk) begin
        word_t w;
        if (m_known) begin
            check("out_valid", bus.out_valid, exp_q.size() > 0);
            check("busy", busy, (exp_q.size() > 0) || m_done);
            check("drain_done", drain_done, m_done);
            check("missed", missed, m_missed);
            if (exp_q.size() > 0) begin
                check("out_acc", bus.out_acc, exp_q[0].acc);
                check("out_q", bus.out_q, exp_q[0].q);
                check("out_row", bus.out_row, exp_q[0].row);
                check("out_col", bus.out_col, exp_q[0].col);
                check("out_last", bus.out_last, exp_q[0].last);
            end
            if (m_chk_zero) begin
                check("rst_acc", bus.out_acc, 0);
                check("rst_q", bus.out_q, 0);
                check("rst_row", bus.out_row, 0);
                check("rst_col", bus.out_col, 0);
                check("rst_last", bus.out_last, 0);
                m_chk_zero = 1'b0;
            end
        end
        if (drain_done) done_cnt++;
        if (reset) begin
            exp_q.delete();
            m_done     = 1'b0;
            m_missed   = 1'b0;
            m_cd_prev  = 1'b0;
            m_known    = 1'b1;
            m_chk_zero = 1'b1;
        end else if (m_known) begin
            m_edge = compute_done && !m_cd_prev;
            if (m_done) begin
                m_done = 1'b0;
                if (m_edge) m_missed = 1'b1;
            end else if (exp_q.size() > 0) begin
                if (m_edge) m_missed = 1'b1;
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    w.acc  = bus.out_acc;
                    w.q    = bus.out_q;
                    w.row  = 8'(bus.out_row);
                    w.col  = 8'(bus.out_col);
                    w.last = bus.out_last;
                    log_q.push_back(w);
                    if (exp_q.size() == 0) m_done = 1'b1;
                end
            end else if (m_edge) begin
                for (int k = 0; k < N; k++) begin
                    w.acc  = pe_vals[OW*k +: OW];
                    w.q    = ref_quant(pe_vals[OW*k +: OW], relu_en);
                    w.row  = 8'(k / NC);
                    w.col  = 8'(k % NC);
                    w.last = (k == N - 1);
                    exp_q.push_back(w);
                end
            end
            m_cd_prev = compute_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_elem(input int k, input logic [OW-1:0] v);
        pe_vals[OW*k +: OW] = v;
    endtask

    task automatic rand_elems();
        for (int k = 0; k < N; k++) set_elem(k, OW'($urandom));
    endtask

    task automatic wait_done(input string name);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < 300) begin
            tick();
            n++;
        end
        check(name, done_cnt != start, 1);
    endtask

    // Capture with the current inputs and wait for the drain to finish.
    task automatic run_drain(input string name);
        log_q.delete();
        compute_done = 1'b1;
        tick();
        wait_done(name);
        compute_done = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [OW-1:0] elem0;
        int n;
        reset = 1'b1;
        compute_done = 1'b0;
        relu_en = 1'b0;
        bus.out_ready = 1'b0;
        pe_vals = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Pin the reference quantizer with hand-computed values.
        check("ref_sat_hi", ref_quant(16'h7FFF, 1'b0), 8'h7F);
        check("ref_sat_lo", ref_quant(16'h8000, 1'b0), 8'h80);
        check("ref_relu", ref_quant(16'h8000, 1'b1), 8'h00);
        check("ref_neg", ref_quant(16'hFFEC, 1'b0), 8'hFE);
        check("ref_128", ref_quant(16'd128, 1'b0), 8'h08);

        // Basic drain; compute_done stays high through it and must not retrigger.
        for (int k = 0; k < N; k++) set_elem(k, OW'(k * 16));
        bus.out_ready = 1'b1;
        run_drain("t1_timeout");
        check("t1_count", log_q.size(), N);
        for (int k = 0; k < N; k++) begin
            if (k < log_q.size()) begin
                check("t1_acc", log_q[k].acc, k * 16);
                check("t1_q", log_q[k].q, k);
                check("t1_row", log_q[k].row, k / NC);
                check("t1_col", log_q[k].col, k % NC);
            end
        end

        // Saturation and ReLU; relu_en flips after capture and must be ignored.
        rand_elems();
        set_elem(0, 16'h7FFF);
        set_elem(1, 16'h8000);
        set_elem(2, 16'hFFEC);
        relu_en = 1'b0;
        run_drain("t2a_timeout");
        check("t2a_count", log_q.size(), N);
        if (log_q.size() >= 3) begin
            check("t2a_q0", log_q[0].q, 8'h7F);
            check("t2a_q1", log_q[1].q, 8'h80);
            check("t2a_q2", log_q[2].q, 8'hFE);
        end
        log_q.delete();
        relu_en = 1'b1;
        compute_done = 1'b1;
        tick();
        relu_en = 1'b0;
        wait_done("t2b_timeout");
        compute_done = 1'b0;
        tick();
        check("t2b_count", log_q.size(), N);
        if (log_q.size() >= 3) begin
            check("t2b_q0", log_q[0].q, 8'h7F);
            check("t2b_q1", log_q[1].q, 8'h00);
            check("t2b_q2", log_q[2].q, 8'h00);
        end

        // Random backpressure while the accumulator bus changes every cycle.
        for (int rep = 0; rep < 4; rep++) begin
            rand_elems();
            relu_en = 1'($urandom_range(0, 1));
            log_q.delete();
            compute_done = 1'b1;
            n = done_cnt;
            tick();
            compute_done = 1'b0;
            for (int c = 0; c < 300 && done_cnt == n; c++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                rand_elems();
                relu_en = 1'($urandom_range(0, 1));
                tick();
            end
            check("t3_timeout", done_cnt != n, 1);
            check("t3_count", log_q.size(), N);
            for (int k = 0; k < N; k++) begin
                if (k < log_q.size()) begin
                    check("t3_row", log_q[k].row, k / NC);
                    check("t3_col", log_q[k].col, k % NC);
                end
            end
            bus.out_ready = 1'b1;
            tick();
        end

        // Missed edge: drop and re-raise compute_done mid-drain.
        rand_elems();
        log_q.delete();
        compute_done = 1'b1;
        tick();
        tick();
        compute_done = 1'b0;
        tick();
        compute_done = 1'b1;
        tick();
        check("t4_missed_set", missed, 1);
        wait_done("t4_timeout");
        compute_done = 1'b0;
        tick();
        check("t4_count", log_q.size(), N);
        check("t4_missed_hold", missed, 1);
        rand_elems();
        run_drain("t4b_timeout");
        check("t4_missed_sticky", missed, 1);

        // Reset mid-drain after the 4th accepted word; compute_done stays high
        // across reset so the first cycle out of reset captures again.
        rand_elems();
        log_q.delete();
        compute_done = 1'b1;
        tick();
        for (int c = 0; c < 100 && log_q.size() < 4; c++) tick();
        check("t5_four_words", log_q.size() >= 4, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_valid_after_rst", bus.out_valid, 0);
        check("t5_busy_after_rst", busy, 0);
        check("t5_missed_cleared", missed, 0);
        elem0 = pe_vals[0 +: OW];
        log_q.delete();
        wait_done("t5_timeout");
        compute_done = 1'b0;
        tick();
        check("t5_count", log_q.size(), N);
        if (log_q.size() > 0) begin
            check("t5_row0", log_q[0].row, 0);
            check("t5_col0", log_q[0].col, 0);
            check("t5_acc0", log_q[0].acc, elem0);
        end
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
